// File: rtl/conv_out_packer.sv
// conv_out_packer
//   Requantises the convolution engine's three result lanes to one byte each,
//   packs the bytes little-endian into 32-bit words, buffers them in a
//   first-word-fall-through word FIFO and drives an AXI4-Stream master toward
//   the DMA S2MM channel. Frame end is marked with tlast/tstrb.
//
//   Optional feature macro: CONV_OUT_PACKER_RELU_EN
//     defined   -> unsigned ReLU bytes (clamp to 0..255)
//     undefined -> signed bytes (clamp to -128..127)
//
// Ports
//   m_axis_aclk      clock
//   m_axis_aresetn   async active-low reset
//   res0/res1/res2   signed result lanes, res0 is the lowest output byte
//   res_v            beat valid (single cycle, no backpressure)
//   res_last         final beat of a frame (qualified by res_v)
//   m_axis_t*        AXI4-Stream master (tvalid/tdata/tstrb/tlast/tready)
//   fifo_level       FIFO occupancy in words
//   err              sticky: FIFO overflow or beat dropped during FLUSH

// Per-lane requantiser: arithmetic shift then saturate to a byte.
module conv_out_packer_lane #(
   parameter int RES_W = 20,
   parameter int SHIFT = 8
) (
   input  logic [RES_W-1:0] res,
   output logic [7:0]       q_byte
);
   logic signed [RES_W-1:0] q;

   assign q = $signed(res) >>> SHIFT;

`ifdef CONV_OUT_PACKER_RELU_EN
   localparam logic signed [RES_W-1:0] Q_MAX = RES_W'(255);

   always_comb begin
      if (q[RES_W-1])     q_byte = 8'h00;
      else if (q > Q_MAX) q_byte = 8'hFF;
      else                q_byte = q[7:0];
   end
`else
   localparam logic signed [RES_W-1:0] Q_MAX = RES_W'(127);
   localparam logic signed [RES_W-1:0] Q_MIN = RES_W'(-128);

   always_comb begin
      if (q > Q_MAX)      q_byte = 8'h7F;
      else if (q < Q_MIN) q_byte = 8'h80;
      else                q_byte = q[7:0];
   end
`endif
endmodule

module conv_out_packer #(
   parameter int RES_W = 20,
   parameter int SHIFT = 8,
   parameter int DEPTH = 16
) (
   input  logic                     m_axis_aclk,
   input  logic                     m_axis_aresetn,
   input  logic [RES_W-1:0]         res0,
   input  logic [RES_W-1:0]         res1,
   input  logic [RES_W-1:0]         res2,
   input  logic                     res_v,
   input  logic                     res_last,
   output logic                     m_axis_tvalid,
   output logic [31:0]              m_axis_tdata,
   output logic [3:0]               m_axis_tstrb,
   output logic                     m_axis_tlast,
   input  logic                     m_axis_tready,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     err
);
   localparam int NUM_LANES = 3;
   localparam int AW        = $clog2(DEPTH);

   typedef enum logic {RUN, FLUSH} state_t;

   // ---------------- requantisation ----------------
   logic [NUM_LANES-1:0][RES_W-1:0] res_lane;
   logic [NUM_LANES-1:0][7:0]       beat_bytes;

   assign res_lane = {res2, res1, res0};

   genvar g;
   generate
      for (g = 0; g < NUM_LANES; g++) begin : g_lane
         conv_out_packer_lane #(.RES_W(RES_W), .SHIFT(SHIFT)) u_lane (
            .res    (res_lane[g]),
            .q_byte (beat_bytes[g])
         );
      end
   endgenerate

   // ---------------- byte accumulator + FSM ----------------
   // Bytes at or above acc_cnt are always zero, so a partial push needs no
   // masking and appending is a plain OR.
   state_t      state, state_nxt;
   logic [47:0] acc_data, acc_data_nxt, rem_data;
   logic [2:0]  acc_cnt, acc_cnt_nxt, rem_cnt;
   logic        flush_pend, flush_pend_nxt;
   logic        push_full, push_part, push_vld, push_last;
   logic [3:0]  push_strb;
   logic        beat_ok, beat_drop;

   always_comb begin
      push_full      = 1'b0;
      push_part      = 1'b0;
      push_vld       = 1'b0;
      push_last      = 1'b0;
      push_strb      = 4'h0;
      rem_cnt        = acc_cnt;
      rem_data       = acc_data;
      beat_ok        = 1'b0;
      beat_drop      = 1'b0;
      acc_data_nxt   = acc_data;
      acc_cnt_nxt    = acc_cnt;
      flush_pend_nxt = flush_pend;
      state_nxt      = state;

      push_full = (acc_cnt >= 3'd4);
      push_part = !push_full && flush_pend && (acc_cnt != 3'd0);
      push_vld  = push_full || push_part;

      if (push_full) begin
         // A full word closes the frame only when nothing is left behind it.
         push_last = flush_pend && (acc_cnt == 3'd4);
         push_strb = 4'hF;
         rem_cnt   = acc_cnt - 3'd4;
         rem_data  = {32'b0, acc_data[47:32]};
      end else if (push_part) begin
         push_last = 1'b1;
         case (acc_cnt)
            3'd1:    push_strb = 4'h1;
            3'd2:    push_strb = 4'h3;
            default: push_strb = 4'h7;
         endcase
         rem_cnt  = 3'd0;
         rem_data = 48'b0;
      end

      beat_ok   = res_v && (state == RUN);
      beat_drop = res_v && (state == FLUSH);

      // rem_cnt never exceeds 3 here, so 3 new bytes always fit in 6.
      acc_data_nxt = rem_data |
                     (beat_ok ? ({24'b0, beat_bytes} << {rem_cnt, 3'b000}) : 48'b0);
      acc_cnt_nxt  = rem_cnt + (beat_ok ? 3'd3 : 3'd0);

      flush_pend_nxt = (flush_pend && !push_last) || (beat_ok && res_last);

      case (state)
         RUN:   if (flush_pend && push_full && (acc_cnt > 3'd4)) state_nxt = FLUSH;
         FLUSH: state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         state      <= RUN;
         acc_data   <= 48'b0;
         acc_cnt    <= 3'd0;
         flush_pend <= 1'b0;
      end else begin
         state      <= state_nxt;
         acc_data   <= acc_data_nxt;
         acc_cnt    <= acc_cnt_nxt;
         flush_pend <= flush_pend_nxt;
      end
   end

   // ---------------- word FIFO (FWFT) ----------------
   logic [36:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic        fifo_full, fifo_empty, pop, wr_en, overflow;

   assign fifo_level = wr_ptr - rd_ptr;
   assign fifo_full  = (fifo_level == (AW+1)'(DEPTH));
   assign fifo_empty = (fifo_level == '0);
   assign pop        = !fifo_empty && m_axis_tready;
   // When full, a same-cycle pop frees the slot being written.
   assign wr_en      = push_vld && (!fifo_full || pop);
   assign overflow   = push_vld && fifo_full && !pop;

   always_ff @(posedge m_axis_aclk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= {push_last, push_strb, acc_data[31:0]};
   end

   always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         err    <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         if (overflow || beat_drop) err <= 1'b1;
      end
   end

   // Payload is gated by empty so the outputs read zero while nothing is
   // queued, including immediately on reset assertion.
   assign m_axis_tvalid = !fifo_empty;
   assign {m_axis_tlast, m_axis_tstrb, m_axis_tdata} =
      fifo_empty ? 37'b0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: tb/tb_conv_out_packer.sv
module tb_conv_out_packer;
   localparam int RES_W = 20;
   localparam int SHIFT = 8;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [RES_W-1:0] res0, res1, res2;
   logic             res_v, res_last;
   logic             tvalid, tlast, tready;
   logic [31:0]      tdata;
   logic [3:0]       tstrb;
   logic [LW-1:0]    fifo_level;
   logic             err;

   int errors = 0;
   int checks = 0;

   logic [7:0]  byte_q[$];
   logic [36:0] exp_q[$];

   always #5 clk = ~clk;

   conv_out_packer #(.RES_W(RES_W), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
      .m_axis_aclk    (clk),
      .m_axis_aresetn (rst_n),
      .res0           (res0),
      .res1           (res1),
      .res2           (res2),
      .res_v          (res_v),
      .res_last       (res_last),
      .m_axis_tvalid  (tvalid),
      .m_axis_tdata   (tdata),
      .m_axis_tstrb   (tstrb),
      .m_axis_tlast   (tlast),
      .m_axis_tready  (tready),
      .fifo_level     (fifo_level),
      .err            (err)
   );

   // Reference byte: floor division by 2^SHIFT, then clamp.
   function automatic logic [7:0] ref_byte(input logic [RES_W-1:0] v);
      int sv, d, q;
      sv = $signed(v);
      d  = 1 << SHIFT;
      if (sv >= 0) q = sv / d;
      else         q = -((-sv + d - 1) / d);
`ifdef CONV_OUT_PACKER_RELU_EN
      if (q < 0)   return 8'h00;
      if (q > 255) return 8'hFF;
`else
      if (q > 127)  return 8'h7F;
      if (q < -128) return 8'h80;
`endif
      return 8'(q);
   endfunction

   // Turn pending frame bytes into expected words. Without frame end a word
   // of exactly 4 bytes is still final-not-last, since more bytes follow.
   function automatic void emit_words(input bit last);
      logic [31:0] d;
      int n;
      while (byte_q.size() >= 4 && !(last && byte_q.size() == 4)) begin
         d = '0;
         for (int i = 0; i < 4; i++) d[8*i +: 8] = byte_q.pop_front();
         exp_q.push_back({1'b0, 4'hF, d});
      end
      if (last && byte_q.size() > 0) begin
         n = byte_q.size();
         d = '0;
         for (int i = 0; i < n; i++) d[8*i +: 8] = byte_q.pop_front();
         exp_q.push_back({1'b1, 4'((1 << n) - 1), d});
      end
   endfunction

   function automatic logic [RES_W-1:0] rand_val();
      if ($urandom_range(0, 1) == 1) return RES_W'($urandom);
      return RES_W'($urandom_range(0, 65535)) - RES_W'(32768);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, obs, expv);
      end
   endtask

   // One clock: observe the handshake at negedge, return 1ns after posedge.
   task automatic tick();
      logic [36:0] w;
      @(negedge clk);
      if (tvalid && tready) begin
         chk("word_expected", 64'(exp_q.size() != 0), 64'(1));
         if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            chk("word", 64'({tlast, tstrb, tdata}), 64'(w));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [RES_W-1:0] v0, v1, v2, input bit last);
      res0 = v0; res1 = v1; res2 = v2;
      res_v = 1'b1; res_last = last;
      byte_q.push_back(ref_byte(v0));
      byte_q.push_back(ref_byte(v1));
      byte_q.push_back(ref_byte(v2));
      emit_words(last);
      tick();
      res_v = 1'b0; res_last = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         tready = ($urandom_range(0, 3) != 0);
         tick();
         n++;
      end
      tready = 1'b1;
      chk("drain_left", 64'(exp_q.size()), 64'(0));
      tick(); tick();
      chk("idle_tvalid", 64'(tvalid), 64'(0));
   endtask

   initial begin
      int n;
      logic [36:0] head;
      rst_n = 1'b0; tready = 1'b0;
      res0 = '0; res1 = '0; res2 = '0; res_v = 1'b0; res_last = 1'b0;

      // reset values
      #12;
      chk("rst_tvalid", 64'(tvalid), 64'(0));
      chk("rst_tdata",  64'(tdata),  64'(0));
      chk("rst_tstrb",  64'(tstrb),  64'(0));
      chk("rst_tlast",  64'(tlast),  64'(0));
      chk("rst_level",  64'(fifo_level), 64'(0));
      chk("rst_err",    64'(err),    64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick(); tick();

      // single-beat frame: latency k -> tvalid after k+1 -> handshake at k+2
      tready = 1'b1;
      beat(20'h01200, 20'hFFD00, 20'h07F00, 1'b1);
      chk("lat_k_tvalid", 64'(tvalid), 64'(0));
      tick();
      chk("lat_k1_tvalid", 64'(tvalid), 64'(1));
`ifdef CONV_OUT_PACKER_RELU_EN
      chk("lat_tdata", 64'(tdata), 64'(32'h007F0012));
`else
      chk("lat_tdata", 64'(tdata), 64'(32'h007FFD12));
`endif
      chk("lat_tstrb", 64'(tstrb), 64'(4'h7));
      chk("lat_tlast", 64'(tlast), 64'(1));
      tick();
      chk("lat_k2_tvalid", 64'(tvalid), 64'(0));

      // four-beat frame, exact multiple of 4 bytes
      tready = 1'b1;
      for (int i = 0; i < 4; i++) beat(20'h07F00, 20'hF7F00, 20'h00100, i == 3);
      drain(30);

      // random frames
      for (int f = 0; f < 6; f++) begin
         tready = 1'b1;
         n = $urandom_range(1, 6);
         for (int b = 0; b < n; b++) begin
            beat(rand_val(), rand_val(), rand_val(), b == n - 1);
            if (b != n - 1 && $urandom_range(0, 3) == 0) tick();
         end
         tick(); tick();
      end
      drain(60);
      chk("rand_err", 64'(err), 64'(0));

      // output stability under a 5-cycle stall
      tready = 1'b0;
      for (int i = 0; i < 3; i++) beat(rand_val(), rand_val(), rand_val(), i == 2);
      tick(); tick(); tick();
      chk("stall_level", 64'(fifo_level), 64'(exp_q.size()));
      chk("stall_tvalid", 64'(tvalid), 64'(1));
      head = exp_q[0];
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_word", 64'({tlast, tstrb, tdata}), 64'(head));
      end
      tready = 1'b1;
      drain(30);

      // beat during FLUSH: third beat leaves 5 bytes, drop beat at k+2
      tready = 1'b1;
      beat(rand_val(), rand_val(), rand_val(), 1'b0);
      beat(rand_val(), rand_val(), rand_val(), 1'b0);
      beat(rand_val(), rand_val(), rand_val(), 1'b1);
      tick();
      res0 = rand_val(); res1 = rand_val(); res2 = rand_val();
      res_v = 1'b1; res_last = 1'b1;
      tick();
      res_v = 1'b0; res_last = 1'b0;
      chk("flush_drop_err", 64'(err), 64'(1));
      drain(30);

      // reset mid-frame with 3 words queued and bytes in the accumulator
      tready = 1'b0;
      for (int i = 0; i < 5; i++) beat(rand_val(), rand_val(), rand_val(), 1'b0);
      tick();
      chk("pre_rst_level", 64'(fifo_level), 64'(3));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_tvalid", 64'(tvalid), 64'(0));
      chk("mid_rst_tdata",  64'(tdata),  64'(0));
      chk("mid_rst_level",  64'(fifo_level), 64'(0));
      chk("mid_rst_err",    64'(err),    64'(0));
      exp_q.delete();
      byte_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick(); tick();
      chk("post_rst_tvalid", 64'(tvalid), 64'(0));
      tready = 1'b1;
      beat(rand_val(), rand_val(), rand_val(), 1'b0);
      beat(rand_val(), rand_val(), rand_val(), 1'b1);
      tick(); tick();
      drain(30);

      // overflow: 8 beats into a stalled DEPTH=4 FIFO -> 6 words, 2 dropped
      tready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         beat(rand_val(), rand_val(), rand_val(), 1'b0);
         if (i == 6) begin
            chk("ovf_pre_err", 64'(err), 64'(0));
            chk("ovf_level",   64'(fifo_level), 64'(DEPTH));
         end
         if (i == 7) chk("ovf_err", 64'(err), 64'(1));
      end
      while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
      tick();
      chk("ovf_level_hold", 64'(fifo_level), 64'(DEPTH));
      tready = 1'b1;
      drain(30);
      chk("ovf_err_sticky", 64'(err), 64'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
